pci_intr_ctrl: RTL and testbench



---
 rtl/pci_intr_pkg.sv | 23 ++
 rtl/pci_intr_throttle.sv | 33 +++
 rtl/pci_intr_ctrl.sv | 122 ++++++++++++
 tb/tb_pci_intr_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pci_intr_pkg.sv
// Shared definitions for the PCI interrupt controller: register word indices
// and the bit-mask helper used to bound writable register fields.
package pci_intr_pkg;

    localparam int unsigned MAX_SRC = 32;
    localparam int unsigned REG_W   = 32;

    localparam logic [1:0] REG_STATUS   = 2'd0;
    localparam logic [1:0] REG_MASK     = 2'd1;
    localparam logic [1:0] REG_THROTTLE = 2'd2;
    localparam logic [1:0] REG_SET      = 2'd3;

    // Mask with the low n bits set; n is clipped at the register width.
    function automatic logic [REG_W-1:0] bit_mask(input int unsigned n);
        logic [REG_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < REG_W; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pci_intr_throttle.sv
// Hold-off counter and registered active-low interrupt output.
// The counter reloads on every INT_N 0->1 transition and suppresses reassertion until it drains.
module pci_intr_throttle #(
    parameter int unsigned THROTTLE_BITS = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     request,
    input  logic [THROTTLE_BITS-1:0] throttle,
    output logic                     INT_N
);

    logic [THROTTLE_BITS-1:0] cnt;
    logic                     int_n_next;

    assign int_n_next = ~(request & (cnt == '0));

    // Load on the edge that releases INT_N, so the new hold-off starts immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            INT_N <= 1'b1;
        end else begin
            INT_N <= int_n_next;
            if (!INT_N && int_n_next) begin
                cnt <= throttle;
            end else if (cnt != '0) begin
                cnt <= cnt - THROTTLE_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/pci_intr_ctrl.sv
// Multi-source interrupt controller: edge-latched pending bits, mask, hold-off, INT_N.
// Define PCI_INTR_SYNC_EN to add a two-flop synchroniser on src_req for asynchronous sources.
module pci_intr_ctrl
    import pci_intr_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 8,
    parameter int unsigned THROTTLE_BITS = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic               reg_valid,
    input  logic               reg_write,
    input  logic [1:0]         reg_addr,
    input  logic [REG_W-1:0]   reg_wdata,
    output logic               reg_ready,
    output logic [REG_W-1:0]   reg_rdata,
    output logic               INT_N
);

    localparam logic [REG_W-1:0] SRC_MSK = bit_mask(NUM_SRC);
    localparam logic [REG_W-1:0] THR_MSK = bit_mask(THROTTLE_BITS);

    logic [NUM_SRC-1:0] src_in;
    logic [NUM_SRC-1:0] src_q;
    logic [REG_W-1:0]   rise;
    logic [REG_W-1:0]   pending;
    logic [REG_W-1:0]   mask;
    logic [REG_W-1:0]   thr;
    logic               acc_q;
    logic [REG_W-1:0]   w1c_c;
    logic [REG_W-1:0]   set_c;
    logic [REG_W-1:0]   rdata_c;
    logic               request;

`ifdef PCI_INTR_SYNC_EN
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src_req;
            sync2 <= sync1;
        end
    end

    assign src_in = sync2;
`else
    assign src_in = src_req;
`endif

    assign rise = REG_W'(src_in & ~src_q);

    // Register write strobes; only valid in the completion cycle of an access.
    always_comb begin
        w1c_c = '0;
        set_c = '0;
        if (acc_q && reg_write) begin
            if (reg_addr == REG_STATUS) w1c_c = reg_wdata;
            if (reg_addr == REG_SET)    set_c = reg_wdata;
        end
    end

    always_comb begin
        rdata_c = '0;
        case (reg_addr)
            REG_STATUS:   rdata_c = pending;
            REG_MASK:     rdata_c = mask;
            REG_THROTTLE: rdata_c = thr;
            REG_SET:      rdata_c = pending & mask;
            default:      rdata_c = '0;
        endcase
    end

    // Hardware rise and software set both win over a same-cycle W1C.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            src_q   <= '0;
            pending <= '0;
        end else begin
            src_q   <= src_in;
            pending <= ((pending & ~w1c_c) | rise | set_c) & SRC_MSK;
        end
    end

    // Two-cycle access: acc_q marks the completion edge, blocking a re-trigger on it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q     <= 1'b0;
            reg_ready <= 1'b0;
            reg_rdata <= '0;
            mask      <= '0;
            thr       <= '0;
        end else begin
            acc_q     <= reg_valid & ~acc_q;
            reg_ready <= acc_q;
            reg_rdata <= (acc_q && !reg_write) ? rdata_c : '0;
            if (acc_q && reg_write && reg_addr == REG_MASK) begin
                mask <= reg_wdata & SRC_MSK;
            end
            if (acc_q && reg_write && reg_addr == REG_THROTTLE) begin
                thr <= reg_wdata & THR_MSK;
            end
        end
    end

    assign request = |(pending & mask);

    pci_intr_throttle #(
        .THROTTLE_BITS (THROTTLE_BITS)
    ) u_throttle (
        .CLK      (CLK),
        .RST      (RST),
        .request  (request),
        .throttle (THROTTLE_BITS'(thr)),
        .INT_N    (INT_N)
    );

endmodule

// File: tb/tb_pci_intr_ctrl.sv
// Directed self-checking bench for pci_intr_ctrl (NUM_SRC=8, THROTTLE_BITS=16).
module tb_pci_intr_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  src_req;
    logic        reg_valid;
    logic        reg_write;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ready;
    logic [31:0] reg_rdata;
    logic        INT_N;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_MASK   = 2'd1;
    localparam logic [1:0] A_THR    = 2'd2;
    localparam logic [1:0] A_SET    = 2'd3;

    pci_intr_ctrl #(
        .NUM_SRC       (8),
        .THROTTLE_BITS (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .src_req   (src_req),
        .reg_valid (reg_valid),
        .reg_write (reg_write),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_ready (reg_ready),
        .reg_rdata (reg_rdata),
        .INT_N     (INT_N)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one access; returns just after the edge that raises reg_ready.
    task automatic reg_acc(input logic wr, input logic [1:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
        int lat;
        @(negedge CLK);
        reg_valid = 1'b1;
        reg_write = wr;
        reg_addr  = a;
        reg_wdata = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!reg_ready && lat < 6);
        check("acc_latency", 32'(lat), 32'd2);
        rd        = reg_rdata;
        reg_valid = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        reg_acc(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        reg_acc(1'b0, a, 32'h0, rd);
        check(tag, rd, exp);
    endtask

    initial begin
        int hi;
        RST       = 1'b1;
        src_req   = '0;
        reg_valid = 1'b0;
        reg_write = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_int_n", 32'(INT_N), 32'd1);
        check("rst_ready", 32'(reg_ready), 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Single enabled source: edge latency and W1C release
        wr_reg(A_MASK, 32'h01);
        @(negedge CLK);
        src_req[0] = 1'b1;
        tick();
        check("a_int_edge_k", 32'(INT_N), 32'd1);
        tick();
        check("a_int_edge_k1", 32'(INT_N), 32'd0);
        @(negedge CLK);
        src_req[0] = 1'b0;
        rd_chk("a_status", A_STATUS, 32'h01);
        rd_chk("a_cause", A_SET, 32'h01);
        wr_reg(A_STATUS, 32'h01);
        check("a_w1c_same", 32'(INT_N), 32'd0);
        tick();
        check("a_w1c_next", 32'(INT_N), 32'd1);
        check("a_rdata_idle", reg_rdata, 32'd0);

        // Masked source latches but does not interrupt until enabled
        wr_reg(A_MASK, 32'h00);
        @(negedge CLK);
        src_req[3] = 1'b1;
        repeat (3) tick();
        check("b_masked_int", 32'(INT_N), 32'd1);
        rd_chk("b_status", A_STATUS, 32'h08);
        wr_reg(A_MASK, 32'h08);
        check("b_unmask_same", 32'(INT_N), 32'd1);
        tick();
        check("b_unmask_next", 32'(INT_N), 32'd0);
        wr_reg(A_STATUS, 32'h08);
        tick();
        check("b_clear", 32'(INT_N), 32'd1);
        @(negedge CLK);
        src_req[3] = 1'b0;

        // Hardware rise on the same edge as W1C of that bit: set wins
        wr_reg(A_MASK, 32'h04);
        wr_reg(A_SET, 32'h04);
        tick();
        check("c_set_int", 32'(INT_N), 32'd0);
        @(negedge CLK);
        reg_valid = 1'b1;
        reg_write = 1'b1;
        reg_addr  = A_STATUS;
        reg_wdata = 32'h04;
        tick();
        src_req[2] = 1'b1;
        check("c_int_pre", 32'(INT_N), 32'd0);
        tick();
        check("c_ready", 32'(reg_ready), 32'd1);
        reg_valid = 1'b0;
        reg_write = 1'b0;
        tick();
        check("c_int_post", 32'(INT_N), 32'd0);
        rd_chk("c_status", A_STATUS, 32'h04);
        check("c_int_hold", 32'(INT_N), 32'd0);
        @(negedge CLK);
        src_req[2] = 1'b0;
        wr_reg(A_STATUS, 32'h04);
        tick();
        check("c_clear", 32'(INT_N), 32'd1);

        // Software set; bits at or above NUM_SRC ignored
        wr_reg(A_MASK, 32'hFF);
        wr_reg(A_SET, 32'h80);
        rd_chk("d_cause", A_SET, 32'h80);
        check("d_int", 32'(INT_N), 32'd0);
        wr_reg(A_SET, 32'h100);
        rd_chk("d_cause_hi", A_SET, 32'h80);
        rd_chk("d_status_hi", A_STATUS, 32'h80);
        wr_reg(A_MASK, 32'hFFFF_FFFF);
        rd_chk("d_mask_hi", A_MASK, 32'hFF);
        wr_reg(A_STATUS, 32'hFF);
        tick();
        check("d_clear", 32'(INT_N), 32'd1);

        // Hold-off of 10 after deassertion, source re-raised immediately
        wr_reg(A_THR, 32'h1234_000A);
        rd_chk("e_thr", A_THR, 32'h0000_000A);
        wr_reg(A_MASK, 32'h01);
        @(negedge CLK);
        src_req[0] = 1'b1;
        tick();
        tick();
        check("e_int_on", 32'(INT_N), 32'd0);
        @(negedge CLK);
        src_req[0] = 1'b0;
        wr_reg(A_STATUS, 32'h01);
        check("e_w1c_same", 32'(INT_N), 32'd0);
        @(negedge CLK);
        src_req[0] = 1'b1;
        tick();
        check("e_deassert", 32'(INT_N), 32'd1);
        hi = 0;
        repeat (10) begin
            tick();
            if (INT_N) hi++;
        end
        check("e_holdoff", 32'(hi), 32'd10);
        tick();
        check("e_reassert", 32'(INT_N), 32'd0);
        @(negedge CLK);
        src_req[0] = 1'b0;

        // Asynchronous reset while INT_N asserted
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("f_async_int_n", 32'(INT_N), 32'd1);
        check("f_async_ready", 32'(reg_ready), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        rd_chk("f_status", A_STATUS, 32'h0);
        rd_chk("f_mask", A_MASK, 32'h0);
        rd_chk("f_thr", A_THR, 32'h0);
        rd_chk("f_cause", A_SET, 32'h0);
        check("f_int_n", 32'(INT_N), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
